// File: rtl/c432_top.sv
// c432_top: 27-channel interrupt priority encoder (3 groups x 9 channels)
// with registered outputs.
// Group A has the highest priority, then B, then C.
// Within the selected group, the lowest enabled index wins.
// Optional build macro C432_TOP_INPUT_REG_EN adds an input register
// stage, which raises the latency from 1 to 2 edges.
module c432_top (
    input  logic clock,
    input  logic reset,
    input  logic input_0,  input  logic input_1,  input  logic input_2,
    input  logic input_3,  input  logic input_4,  input  logic input_5,
    input  logic input_6,  input  logic input_7,  input  logic input_8,
    input  logic input_9,  input  logic input_10, input  logic input_11,
    input  logic input_12, input  logic input_13, input  logic input_14,
    input  logic input_15, input  logic input_16, input  logic input_17,
    input  logic input_18, input  logic input_19, input  logic input_20,
    input  logic input_21, input  logic input_22, input  logic input_23,
    input  logic input_24, input  logic input_25, input  logic input_26,
    input  logic input_27, input  logic input_28, input  logic input_29,
    input  logic input_30, input  logic input_31, input  logic input_32,
    input  logic input_33, input  logic input_34, input  logic input_35,
    output logic po0,
    output logic po1,
    output logic po2,
    output logic po3,
    output logic po4,
    output logic po5,
    output logic po6
);

    localparam int unsigned N_CH = 9;
    localparam int unsigned CH_W = 4;
    localparam int unsigned IN_W = 4 * N_CH;

    logic [IN_W-1:0] in_raw;
    logic [IN_W-1:0] in_use;
    logic [N_CH-1:0] grp_a, grp_b, grp_c, chan_en;
    logic [N_CH-1:0] qual_a_c, qual_b_c, qual_c_c, sel_c;
    logic            pa_c, pb_c, pc_c;
    logic [CH_W-1:0] ch_c;
    logic            pa_q, pb_q, pc_q;
    logic [CH_W-1:0] ch_q;

    assign in_raw = {input_35, input_34, input_33, input_32, input_31, input_30,
                     input_29, input_28, input_27, input_26, input_25, input_24,
                     input_23, input_22, input_21, input_20, input_19, input_18,
                     input_17, input_16, input_15, input_14, input_13, input_12,
                     input_11, input_10, input_9,  input_8,  input_7,  input_6,
                     input_5,  input_4,  input_3,  input_2,  input_1,  input_0};

`ifdef C432_TOP_INPUT_REG_EN
    logic [IN_W-1:0] in_q;

    // Input capture stage ahead of the encoder
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_q <= '0;
        end else begin
            in_q <= in_raw;
        end
    end

    assign in_use = in_q;
`else
    assign in_use = in_raw;
`endif

    assign grp_a   = in_use[N_CH-1:0];
    assign grp_b   = in_use[2*N_CH-1:N_CH];
    assign grp_c   = in_use[3*N_CH-1:2*N_CH];
    assign chan_en = in_use[4*N_CH-1:3*N_CH];

    // Lowest set bit index; 0 when nothing is set
    function automatic logic [CH_W-1:0] lowest_idx(input logic [N_CH-1:0] q);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (q[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

    // Group priority first, then lowest qualified index within the group
    always_comb begin
        qual_a_c = grp_a & chan_en;
        qual_b_c = grp_b & chan_en;
        qual_c_c = grp_c & chan_en;
        pa_c     = |qual_a_c;
        pb_c     = !pa_c && (|qual_b_c);
        pc_c     = !pa_c && !pb_c && (|qual_c_c);
        sel_c    = '0;
        if (pa_c) begin
            sel_c = qual_a_c;
        end else if (pb_c) begin
            sel_c = qual_b_c;
        end else if (pc_c) begin
            sel_c = qual_c_c;
        end
        ch_c = lowest_idx(sel_c);
    end

    // Output register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pa_q <= 1'b0;
            pb_q <= 1'b0;
            pc_q <= 1'b0;
            ch_q <= '0;
        end else begin
            pa_q <= pa_c;
            pb_q <= pb_c;
            pc_q <= pc_c;
            ch_q <= ch_c;
        end
    end

    assign po0 = pa_q;
    assign po1 = pb_q;
    assign po2 = pc_q;
    assign po3 = ch_q[0];
    assign po4 = ch_q[1];
    assign po5 = ch_q[2];
    assign po6 = ch_q[3];

endmodule

// File: tb/tb_c432_top.sv
// Directed, table-driven bench for c432_top; adapts its latency to the
// C432_TOP_INPUT_REG_EN build macro.
module tb_c432_top;

`ifdef C432_TOP_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] a = '0, b = '0, c = '0, e = '0;
    logic       po0, po1, po2, po3, po4, po5, po6;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [8:0] a, b, c, e;
        logic [6:0] exp;   // {ch[3:0], pc, pb, pa}
    } vec_t;

    vec_t vecs[$];

    always #5 clock = ~clock;

    c432_top dut (
        .clock(clock), .reset(reset),
        .input_0(a[0]),  .input_1(a[1]),  .input_2(a[2]),  .input_3(a[3]),
        .input_4(a[4]),  .input_5(a[5]),  .input_6(a[6]),  .input_7(a[7]),
        .input_8(a[8]),
        .input_9(b[0]),  .input_10(b[1]), .input_11(b[2]), .input_12(b[3]),
        .input_13(b[4]), .input_14(b[5]), .input_15(b[6]), .input_16(b[7]),
        .input_17(b[8]),
        .input_18(c[0]), .input_19(c[1]), .input_20(c[2]), .input_21(c[3]),
        .input_22(c[4]), .input_23(c[5]), .input_24(c[6]), .input_25(c[7]),
        .input_26(c[8]),
        .input_27(e[0]), .input_28(e[1]), .input_29(e[2]), .input_30(e[3]),
        .input_31(e[4]), .input_32(e[5]), .input_33(e[6]), .input_34(e[7]),
        .input_35(e[8]),
        .po0(po0), .po1(po1), .po2(po2), .po3(po3),
        .po4(po4), .po5(po5), .po6(po6)
    );

    function automatic logic [6:0] mk(input logic pa, input logic pb,
                                      input logic pc, input int ch);
        logic [3:0] chv;
        chv = 4'(ch);
        return {chv, pc, pb, pa};
    endfunction

    task automatic check(input string name, input logic [6:0] exp);
        logic [6:0] got;
        got = {po6, po5, po4, po3, po2, po1, po0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got ch=%0d pc=%b pb=%b pa=%b, expected ch=%0d pc=%b pb=%b pa=%b",
                     name, got[6:3], got[2], got[1], got[0],
                     exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(input logic [8:0] va, input logic [8:0] vb,
                         input logic [8:0] vc, input logic [8:0] ve);
        a = va; b = vb; c = vc; e = ve;
    endtask

    task automatic add(input string n, input logic [8:0] va, input logic [8:0] vb,
                       input logic [8:0] vc, input logic [8:0] ve, input logic [6:0] x);
        vec_t v;
        v.name = n; v.a = va; v.b = vb; v.c = vc; v.e = ve; v.exp = x;
        vecs.push_back(v);
    endtask

    initial begin
        logic [6:0] zero;
        logic [6:0] pa3;
        zero = 7'd0;
        pa3  = mk(1, 0, 0, 3);

        add("all_zero",        9'h000, 9'h000, 9'h000, 9'h000, zero);
        add("a3_over_b0",      9'h008, 9'h001, 9'h000, 9'h009, pa3);
        add("b5_masked_c7",    9'h000, 9'h020, 9'h080, 9'h080, mk(0, 0, 1, 7));
        add("b5_enabled",      9'h000, 9'h020, 9'h080, 9'h0A0, mk(0, 1, 0, 5));
        add("a8_a2_lowest",    9'h104, 9'h000, 9'h000, 9'h1FF, mk(1, 0, 0, 2));
        add("c8_only",         9'h000, 9'h000, 9'h100, 9'h1FF, mk(0, 0, 1, 8));
        add("a_all_no_en",     9'h1FF, 9'h1FF, 9'h1FF, 9'h000, zero);
        add("a0_ch0",          9'h001, 9'h000, 9'h000, 9'h001, mk(1, 0, 0, 0));
        add("b8_over_c0",      9'h000, 9'h100, 9'h001, 9'h1FF, mk(0, 1, 0, 8));
        add("all_ones",        9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, mk(1, 0, 0, 0));
        add("c_all_en8",       9'h000, 9'h000, 9'h1FF, 9'h100, mk(0, 0, 1, 8));
        add("a4_masked_b0",    9'h010, 9'h1FF, 9'h000, 9'h1EF, mk(0, 1, 0, 0));
        add("en_only",         9'h000, 9'h000, 9'h000, 9'h1FF, zero);

        // Reset held with live requests: outputs must stay cleared
        drive(9'h1FF, 9'h000, 9'h000, 9'h1FF);
        #2 check("reset_async_start", zero);
        repeat (3) @(posedge clock);
        #1 check("reset_held_inputs", zero);
        @(negedge clock);
        drive('0, '0, '0, '0);
        reset = 1'b0;

        // Idle stream gives zero every cycle
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1 check("idle_cycle", zero);
        end

        // Latency check from a known-zero output state
        @(negedge clock);
        drive(9'h008, 9'h001, 9'h000, 9'h009);
        #1 check("latency_pre_edge", zero);
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clock);
            #1 check("latency_edge", (k == LAT) ? pa3 : zero);
        end

        // Stable inputs give stable outputs
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1 check("stable_hold", pa3);
        end

        // Table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e);
            repeat (LAT) @(posedge clock);
            #1 check(vecs[i].name, vecs[i].exp);
        end

        // Mid-stream reset while PA is active
        @(negedge clock);
        drive(9'h008, 9'h001, 9'h000, 9'h009);
        repeat (LAT + 1) @(posedge clock);
        #1 check("pre_reset_pa", pa3);
        #2 reset = 1'b1;
        #1 check("reset_async_mid", zero);
        repeat (2) @(posedge clock);
        #1 check("reset_mid_held", zero);
        @(negedge clock);
        reset = 1'b0;
        #1 check("after_release_no_edge", zero);
        @(posedge clock);
        #1 check("first_edge_after_release", (LAT == 1) ? pa3 : zero);
        @(posedge clock);
        #1 check("second_edge_after_release", pa3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute runtime guard
    initial begin
        #100000;
        $display("FAIL timeout: got no end of test, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/c432_top.md
C432_TOP -- requirements
Module: c432_top

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high clear of all registers.
REQ-004 input_0..input_8  input  1 each  group A request bits, where A[i] = input_i (highest-priority group).
REQ-005 input_9..input_17  input  1 each  group B request bits, where B[i] = input_(9+i).
REQ-006 input_18..input_26  input  1 each  group C request bits, where C[i] = input_(18+i) (lowest-priority group).
REQ-007 input_27..input_35  input  1 each  channel enable bits, where E[i] = input_(27+i); E[i] applies to channel i of all three groups.
REQ-008 po0  output  1  PA, meaning group A has a qualified request.
REQ-009 po1  output  1  PB, meaning group B is selected.
REQ-010 po2  output  1  PC, meaning group C is selected.
REQ-011 po3..po6  output  1 each  CH[0..3], the selected channel index, LSB on po3.

Function
REQ-012 The block SHALL implement a 27-channel interrupt priority encoder over 3 groups of 9 channels.
REQ-013 A channel is qualified when its group bit X[i]=1 and E[i]=1.
REQ-014 PA SHALL be 1 when any channel of group A is qualified.
REQ-015 PB SHALL be 1 when no channel of group A is qualified and any channel of group B is qualified.
REQ-016 PC SHALL be 1 when no channel of group A or group B is qualified and any channel of group C is qualified.
REQ-017 At most one of PA, PB or PC SHALL be 1 at any time.
REQ-018 CH SHALL be the lowest qualified index i (0..8) in the selected group.
REQ-019 CH SHALL be 4'b0000 when no group is selected.
REQ-020 CH SHALL never exceed 8.
REQ-021 When no channel is qualified, all outputs SHALL be 0; an idle result cannot be told apart from channel 0 without P flags, which is by design.
REQ-022 All outputs SHALL be registered, and the encoder is purely combinational between registers.
REQ-023 When C432_TOP_INPUT_REG_EN is undefined, outputs SHALL reflect the inputs sampled at rising edge N, visible after edge N (latency 1).
REQ-024 Inputs held stable SHALL give stable outputs; there is no internal history or sticky state.
REQ-025 Simultaneous requests in multiple groups SHALL be resolved strictly by group priority first, then by lowest index.

Reset
REQ-026 Asserting reset SHALL immediately clear all outputs po0..po6 to 0 and clear any input pipeline registers to 0, without waiting for a clock edge.
REQ-027 While reset is high, outputs SHALL stay 0 regardless of the inputs.
REQ-028 The first rising edge after reset deasserts SHALL sample the inputs normally.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight result.

Configuration
REQ-030 Macro C432_TOP_INPUT_REG_EN: when defined, all 36 inputs SHALL first be captured in an input register stage before the encoder, and a result SHALL appear 2 rising edges after the inputs are sampled (latency 2).
REQ-031 Without C432_TOP_INPUT_REG_EN, there SHALL be no input register stage and the latency is 1.
REQ-032 The encoding function SHALL be identical in both builds.

Verification
REQ-033 All inputs 0, reset released -> po0..po6 = 0 on every cycle.
REQ-034 A[3]=1, E[3]=1, B[0]=1, E[0]=1 -> po0=1, po1=0, po2=0, CH=3 after latency.
REQ-035 B[5]=1 with E[5]=0, C[7]=1 with E[7]=1 -> PC=1, CH=7; then set E[5]=1 -> PB=1, CH=5.
REQ-036 A[8]=1, A[2]=1, E[all]=1 -> PA=1, CH=2; then A=0, C[8]=1 -> PC=1, CH=8.
REQ-037 Assert reset mid-stream while PA=1 -> outputs go to 0 without a clock edge and remain 0 until the first edge after release.
REQ-038 Run REQ-034 in both builds -> the result appears after 1 edge without C432_TOP_INPUT_REG_EN and after 2 edges with it.
